// File: rtl/alu_seq_param.sv
// alu_seq_param: multi-cycle add/sub/mul/div ALU with serial operand load and handshaked result words
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, s        op request and opcode (00 ADD, 01 SUB, 10 MUL, 11 DIV), sampled in IDLE
//   inbus           operand X the cycle after acceptance, operand Y the cycle after that
//   outbus          result word while out_valid, else 0
//   out_valid       outbus carries a result word
//   finish          last result word of the op
//   busy            high outside IDLE
//   negative, zero, carry, overflow, div_zero   result flags, updated on entry to OUT_LO
module alu_seq_param #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             finish,
    output logic             busy,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, EXEC, FIX, OUT_HI, OUT_LO} state_t;

    state_t state, state_nx;
    logic [1:0] op;
    logic [WIDTH-1:0] x, y, q, res_hi, res_lo;
    // Shared accumulator: Booth/shift-add upper half for MUL, partial remainder for DIV.
    // Two guard bits cover the +-2*divisor range and the MIN multiplicand.
    logic [WIDTH+1:0] a;
    logic q_1;
    logic [CW-1:0] cnt;
    logic p_n, p_z, p_v, p_dz;

    logic [WIDTH-1:0] x_mag, y_mag, add_r, quo, rem;
    logic [WIDTH:0] sum, dif;
    logic [WIDTH+1:0] m_ext, d_ext, mul_t, r2, div_t, r_fix;
    logic add_c, add_v, mul_top, q_neg, r_neg, div_ovf, mul_ovf, y_zero, last;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return (SIGNED && v[WIDTH-1]) ? -v : v;
    endfunction

    always_comb begin
        x_mag   = mag(x);
        y_mag   = mag(y);
        d_ext   = {2'b00, y_mag};
        m_ext   = SIGNED ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
        sum     = {1'b0, x} + {1'b0, y};
        dif     = {1'b0, x} - {1'b0, y};
        add_r   = op[0] ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
        add_c   = op[0] ? dif[WIDTH] : sum[WIDTH];
        add_v   = (op[0] ? (x[WIDTH-1] != y[WIDTH-1]) : (x[WIDTH-1] == y[WIDTH-1]))
                  && (add_r[WIDTH-1] != x[WIDTH-1]);
        // Booth looks at the {q0, q_1} pair; shift-add only at q0
        mul_t   = SIGNED ? ((q[0] == q_1) ? a : (q[0] ? a - m_ext : a + m_ext))
                         : (q[0] ? a + m_ext : a);
        mul_top = SIGNED ? mul_t[WIDTH+1] : 1'b0;
        mul_ovf = SIGNED ? (a[WIDTH-1:0] != {WIDTH{q[WIDTH-1]}}) : (a[WIDTH-1:0] != '0);
        // Non-restoring step: shift in next dividend bit, then add or subtract by sign
        r2      = {a[WIDTH:0], q[WIDTH-1]};
        div_t   = a[WIDTH+1] ? r2 + d_ext : r2 - d_ext;
        r_fix   = a[WIDTH+1] ? a + d_ext : a;
        q_neg   = SIGNED && (x[WIDTH-1] ^ y[WIDTH-1]);
        r_neg   = SIGNED && x[WIDTH-1];
        quo     = q_neg ? -q : q;
        rem     = r_neg ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
        div_ovf = SIGNED && (x == {1'b1, {(WIDTH-1){1'b0}}}) && (&y);
        y_zero  = (y == '0);
        last    = (cnt == CW'(WIDTH-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD_X : IDLE;
            LOAD_X:  state_nx = LOAD_Y;
            LOAD_Y:  state_nx = EXEC;
            EXEC:    state_nx = !op[1] ? OUT_LO : ((op[0] && y_zero) || last) ? FIX : EXEC;
            FIX:     state_nx = OUT_HI;
            OUT_HI:  state_nx = OUT_LO;
            OUT_LO:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op <= '0;
            x <= '0;
            y <= '0;
            q <= '0;
            a <= '0;
            q_1 <= 1'b0;
            cnt <= '0;
            res_hi <= '0;
            res_lo <= '0;
            p_n <= 1'b0;
            p_z <= 1'b0;
            p_v <= 1'b0;
            p_dz <= 1'b0;
            negative <= 1'b0;
            zero <= 1'b0;
            carry <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) op <= s;
                LOAD_X: x <= inbus;
                LOAD_Y: begin
                    y <= inbus;
                    a <= '0;
                    q <= (op == 2'b11) ? x_mag : inbus;
                    q_1 <= 1'b0;
                    cnt <= '0;
                end
                EXEC: begin
                    if (!op[1]) begin
                        res_lo <= add_r;
                        negative <= add_r[WIDTH-1];
                        zero <= (add_r == '0);
                        carry <= add_c;
                        overflow <= add_v;
                        div_zero <= 1'b0;
                    end else if (op[0]) begin
                        a <= div_t;
                        q <= {q[WIDTH-2:0], ~div_t[WIDTH+1]};
                        cnt <= cnt + 1'b1;
                    end else begin
                        a <= {mul_top, mul_t[WIDTH+1:1]};
                        q <= {mul_t[0], q[WIDTH-1:1]};
                        q_1 <= q[0];
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!op[0]) begin
                        res_hi <= a[WIDTH-1:0];
                        res_lo <= q;
                        p_n <= a[WIDTH-1];
                        p_z <= ({a[WIDTH-1:0], q} == '0);
                        p_v <= mul_ovf;
                        p_dz <= 1'b0;
                    end else if (y_zero) begin
                        res_hi <= '1;
                        res_lo <= x;
                        p_n <= 1'b1;
                        p_z <= 1'b0;
                        p_v <= 1'b0;
                        p_dz <= 1'b1;
                    end else begin
                        res_hi <= quo;
                        res_lo <= rem;
                        p_n <= quo[WIDTH-1];
                        p_z <= (quo == '0);
                        p_v <= div_ovf;
                        p_dz <= 1'b0;
                    end
                end
                OUT_HI: begin
                    negative <= p_n;
                    zero <= p_z;
                    carry <= 1'b0;
                    overflow <= p_v;
                    div_zero <= p_dz;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT_HI) || (state == OUT_LO);
    assign finish    = (state == OUT_LO);
    assign outbus    = (state == OUT_HI) ? res_hi : (state == OUT_LO) ? res_lo : '0;
endmodule
